// File: rtl/atan2_cordic.sv
// Iterative vectoring-mode CORDIC: atan2(y,x) in turn-scaled integer angle plus vector magnitude.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales mag_out by 1/K (true magnitude).
module atan2_cordic #(
  parameter int ITER  = 24,
  parameter int ANG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x_in,
  input  logic [31:0]      y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ANG_W-1:0] angle_out,
  output logic [32:0]      mag_out
);
  localparam int CW = $clog2(ITER + 1);
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [31:0] GAIN_K = 32'h9B74EDA8;
`endif
  typedef logic [ANG_W-1:0] ang_t;

  // atan(2^-i) by its power series in Q60, then scaled so 2^ANG_W is one full turn.
  function automatic ang_t atan_code(input int i);
    logic [127:0] acc, term;
    int sh;
    acc = '0;
    if (i == 0) return ang_t'(1) << (ANG_W - 3);
    for (int k = 0; k < 64; k++) begin
      sh = 60 - i * (2 * k + 1);
      if (sh >= 0) begin
        term = (128'd1 << sh) / 128'(2 * k + 1);
        acc  = (k % 2 == 0) ? acc + term : acc - term;
      end
    end
    acc = ((acc << (ANG_W - 1)) + (PI_Q60 >> 1)) / PI_Q60;
    return acc[ANG_W-1:0];
  endfunction

  logic [ITER-1:0][ANG_W-1:0] lut;
  for (genvar g = 0; g < ITER; g++) begin : g_lut
    localparam ang_t C = atan_code(g);
    assign lut[g] = C;
  end

  typedef enum logic [2:0] {
    IDLE,
    PREROT,
    ROTATE,
`ifdef CORDIC_GAIN_COMP_EN
    GAIN,
`endif
    DONE
  } state_t;

  state_t             state_q;
  logic signed [33:0] x_q, y_q;
  ang_t               z_q, angle_q;
  logic [CW-1:0]      cnt_q;
  logic [4:0]         sh_q;
  logic               zero_q, in_ready_q, out_valid_q;
  logic [32:0]        mag_q;

  // Pre-rotation into the right half-plane, then normalisation so small vectors
  // keep full angular resolution; the shift is undone on the magnitude at the end.
  logic signed [33:0] px, py;
  ang_t               pz;
  logic [32:0]        mv;
  logic [4:0]         psh;
  always_comb begin
    px = x_q;
    py = y_q;
    pz = '0;
    if (x_q[33]) begin
      px = -x_q;
      py = -y_q;
      pz = ang_t'(1) << (ANG_W - 1);
    end
    mv  = 33'(px) | 33'(py[33] ? -py : py);
    psh = '0;
    for (int b = 0; b <= 30; b++)
      if (mv[b]) psh = 5'(30 - b);
    if (mv[32:31] != 2'b00) psh = '0;
  end

  logic signed [33:0] xs, ys, rx, ry;
  ang_t               rz;
  always_comb begin
    xs = x_q >>> cnt_q;
    ys = y_q >>> cnt_q;
    if (!y_q[33]) begin
      rx = x_q + ys;
      ry = y_q - xs;
      rz = z_q + lut[cnt_q];
    end else begin
      rx = x_q - ys;
      ry = y_q + xs;
      rz = z_q - lut[cnt_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      sh_q        <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      angle_q     <= '0;
      mag_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_ready_q && in_valid) begin
            x_q        <= {{2{x_in[31]}}, x_in};
            y_q        <= {{2{y_in[31]}}, y_in};
            in_ready_q <= 1'b0;
            state_q    <= PREROT;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        PREROT: begin
          x_q     <= px <<< psh;
          y_q     <= py <<< psh;
          z_q     <= pz;
          sh_q    <= psh;
          zero_q  <= (mv == '0);
          cnt_q   <= '0;
          state_q <= ROTATE;
        end
        ROTATE: begin
          if (cnt_q == CW'(ITER)) begin
            angle_q <= zero_q ? '0 : z_q;
`ifdef CORDIC_GAIN_COMP_EN
            state_q <= GAIN;
`else
            mag_q       <= x_q[32:0] >> sh_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`endif
          end else begin
            x_q   <= rx;
            y_q   <= ry;
            z_q   <= rz;
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        GAIN: begin
          mag_q       <= 33'((66'(x_q[32:0]) * 66'(GAIN_K)) >> 32) >> sh_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign angle_out = angle_q;
  assign mag_out   = mag_q;
endmodule

// File: tb/tb_atan2_cordic.sv
// Scoreboard bench for atan2_cordic: driver pushes $atan2/$sqrt expectations, monitor pops on out_valid.
module tb_atan2_cordic;
  localparam int ITER = 24;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = ITER + 3;
  localparam bit COMP = 1'b1;
`else
  localparam int LAT  = ITER + 2;
  localparam bit COMP = 1'b0;
`endif
  localparam real TWO32 = 4294967296.0;
  localparam real TWO31 = 2147483648.0;
  localparam real PI    = 3.14159265358979323846;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x_in, y_in, angle_out;
  logic [32:0] mag_out;
  int          total, bad;
  real         kgain;
  bit          mon_busy;

  typedef struct {
    real    ang;
    real    atol;
    real    mag;
    real    mtol;
    longint tacc;
    int     hold;
  } exp_t;
  exp_t sb[$];

  atan2_cordic dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .angle_out(angle_out), .mag_out(mag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic chk_tol(input string name, input real act, input real want, input real tol);
    total++;
    if (act - want > tol || want - act > tol) begin
      bad++;
      $display("FAIL %s: got %0.2f want %0.2f (+/-%0.1f)", name, act, want, tol);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input real mtol, input int hold);
    exp_t m;
    real  xr, yr, a;
    xr     = real'($signed(x));
    yr     = real'($signed(y));
    m.hold = hold;
    m.tacc = 0;
    if (x == 0 && y == 0) begin
      m.ang = 0.0; m.atol = 0.0; m.mag = 0.0; m.mtol = 0.0;
      return m;
    end
    a = $atan2(yr, xr) / (2.0 * PI) * TWO32;
    if (a < 0.0) a += TWO32;
    m.ang  = a;
    m.atol = 256.0;
    m.mag  = $sqrt(xr * xr + yr * yr) * (COMP ? 1.0 : kgain);
    m.mtol = mtol;
    return m;
  endfunction

  task automatic send(input logic [31:0] x, input logic [31:0] y, input real mtol,
                      input int hold, input int junk);
    exp_t e;
    int   g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      chk("send_wait_ready", in_ready, 1);
      return;
    end
    x_in = x; y_in = y; in_valid = 1'b1;
    @(posedge clk);
    e      = model(x, y, mtol, hold);
    e.tacc = longint'($time);
    sb.push_back(e);
    #1;
    if (junk > 0) begin
      // keep in_valid asserted with other data while busy: must be ignored
      x_in = ~x; y_in = y ^ 32'h5555_5555;
      repeat (junk) @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic abort_run(input logic [31:0] x, input logic [31:0] y);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("abort_wait_ready", in_ready, 1);
    x_in = x; y_in = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_angle_clr", angle_out, 0);
    chk("abort_mag_clr", mag_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("abort_ready_after", in_ready, 1);
    repeat (ITER + 6) @(negedge clk);
  endtask

  initial begin : mon
    exp_t        e;
    logic [31:0] a0;
    logic [32:0] m0;
    int          hold;
    bit          rel;
    real         d;
    mon_busy = 1'b0; rel = 1'b0; hold = 0; out_ready = 1'b1; a0 = '0; m0 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_busy = 1'b0; rel = 1'b0; out_ready = 1'b1;
      end else begin
        if (rel) begin
          chk("release_out_valid", out_valid, 0);
          chk("release_in_ready", in_ready, 1);
          rel = 1'b0;
        end
        if (out_valid && !mon_busy) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("latency", longint'($time), e.tacc + LAT * 10 + 5);
            d = real'(angle_out) - e.ang;
            if (d > TWO31) d -= TWO32;
            else if (d < -TWO31) d += TWO32;
            chk_tol("angle", e.ang + d, e.ang, e.atol);
            chk_tol("mag", real'(mag_out), e.mag, e.mtol);
            a0 = angle_out; m0 = mag_out; hold = e.hold; mon_busy = 1'b1;
          end
        end else if (out_valid && mon_busy) begin
          chk("hold_angle", angle_out, a0);
          chk("hold_mag", mag_out, m0);
          chk("hold_in_ready", in_ready, 0);
        end
        if (mon_busy) begin
          if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
          end else begin
            out_ready = 1'b1;
            mon_busy  = 1'b0;
            rel       = 1'b1;
          end
        end
      end
    end
  end

  initial begin : drv
    logic [31:0] rx, ry;
    real         tol;
    int          g;
    kgain = 1.0;
    for (int i = 0; i < ITER; i++) kgain *= $sqrt(1.0 + 2.0 ** (-2.0 * i));
    total = 0; bad = 0;
    in_valid = 1'b0; x_in = '0; y_in = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_angle", angle_out, 0);
    chk("rst_mag", mag_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", in_ready, 1);

    send(32'd1000, 32'd0, 2.0, 0, 0);
    send(32'd0, 32'd1000, 2.0, 0, 0);
    send(32'd0, -32'sd1000, 2.0, 1, 0);
    send(-32'sd1000, 32'd0, 2.0, 0, 0);
    send(32'd1000, 32'd1000, 2.0, 0, 0);
    send(32'h8000_0000, 32'h8000_0000, 32.0, 0, 0);
    send(32'd0, 32'd0, 0.0, 0, 0);
    send(32'd3000, -32'sd4000, 2.0, 10, ITER / 2);

    abort_run(32'd12345, -32'sd6789);
    send(-32'sd700, 32'd900, 2.0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0: begin rx = $urandom; ry = $urandom; tol = 32.0; end
        1: begin
          rx = 32'($urandom_range(0, 8191)) - 32'd4096;
          ry = 32'($urandom_range(0, 8191)) - 32'd4096;
          tol = 3.0;
        end
        default: begin
          rx = $urandom;
          ry = 32'($urandom_range(0, 15)) - 32'd8;
          tol = 32.0;
        end
      endcase
      send(rx, ry, tol, $urandom_range(0, 3), 0);
    end

    g = 0;
    while ((sb.size() != 0 || mon_busy) && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
